// File: rtl/pb_sw_conditioner.sv
// -----------------------------------------------------------------------------
// pb_sw_conditioner
//
// Conditions the board's raw push-button and slide-switch pins before they
// reach the debugger core. Each of the 12 pins is passed through a two-flop
// synchronizer into the clk_i domain. It is then debounced by its own counter
// and produces a clean level plus one-cycle edge strobes.
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_i         synchronous active-high reset
//   pb_i[3:0]     raw push-button pins (asynchronous)
//   sw_i[7:0]     raw slide-switch pins (asynchronous)
//   pb_level_o    debounced button levels, 1 = pressed
//   pb_press_o    one-cycle strobe per button on a 0->1 level change
//   pb_release_o  one-cycle strobe per button on a 1->0 level change
//   sw_level_o    debounced switch levels
//   sw_change_o   one-cycle strobe when any switch level changes
//
// Channel layout inside the block: bits [3:0] are buttons, bits [11:4] are
// switches.
// -----------------------------------------------------------------------------
module pb_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter bit PB_ACTIVE_LOW   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] pb_i,
    input  logic [7:0] sw_i,
    output logic [3:0] pb_level_o,
    output logic [3:0] pb_press_o,
    output logic [3:0] pb_release_o,
    output logic [7:0] sw_level_o,
    output logic       sw_change_o
);

    localparam int               N_CH     = 12;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       PB_INV   = PB_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  synced;
    logic [N_CH-1:0]  stable;
    logic [N_CH-1:0]  stable_nxt;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];
    logic [3:0]       pb_press;
    logic [3:0]       pb_release;
    logic             sw_change;

    // Inversion sits after the second flop so the synchronizer itself only
    // ever sees raw pin values.
    assign synced = {sync2[11:4], sync2[3:0] ^ PB_INV};

    // Debounce decision. The counter tracks how many consecutive cycles the
    // synchronized value has disagreed with the stable value. It clears
    // whenever they agree, so any glitch shorter than DEBOUNCE_CYCLES is
    // forgotten. Clearing at CNT_LAST also means the counter can never wrap.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = '0;
            if (synced[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = synced[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            pb_press   <= '0;
            pb_release <= '0;
            sw_change  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= {sw_i, pb_i};
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // Strobes are computed from the next stable value. They
            // therefore land in the same cycle the level output first shows
            // the change.
            pb_press   <= stable_nxt[3:0] & ~stable[3:0];
            pb_release <= ~stable_nxt[3:0] & stable[3:0];
            sw_change  <= |(stable_nxt[11:4] ^ stable[11:4]);
        end
    end

    assign pb_level_o   = stable[3:0];
    assign sw_level_o   = stable[11:4];
    assign pb_press_o   = pb_press;
    assign pb_release_o = pb_release;
    assign sw_change_o  = sw_change;

endmodule

// File: tb/tb_pb_sw_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pb_sw_conditioner
//
// Three instances share the clock, reset and switch pins:
//   dut_a : DEBOUNCE_CYCLES=4, active-high buttons (pins pb)
//   dut_b : DEBOUNCE_CYCLES=4, active-low buttons  (pins pb_b)
//   dut_c : DEBOUNCE_CYCLES=1, active-high buttons (pins pb)
//
// A reference model predicts every output of every instance each cycle. It
// keeps a window of the last D synchronized samples per instance. A stable
// bit flips only when all D samples in the window oppose it.
// -----------------------------------------------------------------------------
module tb_pb_sw_conditioner;

    // ---------------- clock / reset / pins ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb = 4'h0;
    logic [3:0] pb_b = 4'hF;
    logic [7:0] sw = 8'h00;

    always #5 clk = ~clk;

    logic [3:0] pb_level_a, pb_press_a, pb_release_a;
    logic [7:0] sw_level_a;
    logic       sw_change_a;
    logic [3:0] pb_level_b, pb_press_b, pb_release_b;
    logic [7:0] sw_level_b;
    logic       sw_change_b;
    logic [3:0] pb_level_c, pb_press_c, pb_release_c;
    logic [7:0] sw_level_c;
    logic       sw_change_c;

    pb_sw_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(18), .PB_ACTIVE_LOW(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .pb_i(pb), .sw_i(sw),
        .pb_level_o(pb_level_a), .pb_press_o(pb_press_a), .pb_release_o(pb_release_a),
        .sw_level_o(sw_level_a), .sw_change_o(sw_change_a));

    pb_sw_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(18), .PB_ACTIVE_LOW(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .pb_i(pb_b), .sw_i(sw),
        .pb_level_o(pb_level_b), .pb_press_o(pb_press_b), .pb_release_o(pb_release_b),
        .sw_level_o(sw_level_b), .sw_change_o(sw_change_b));

    pb_sw_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4), .PB_ACTIVE_LOW(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst), .pb_i(pb), .sw_i(sw),
        .pb_level_o(pb_level_c), .pb_press_o(pb_press_c), .pb_release_o(pb_release_c),
        .sw_level_o(sw_level_c), .sw_change_o(sw_change_c));

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int press1_cnt = 0;
    int chg_cnt    = 0;

    // ---------------- reference model ----------------
    // Expected word per instance: {level[3:0], press[3:0], release[3:0], sw[7:0], change}
    logic [62:0] exp_q[$];
    logic [11:0] m_p1   [3];
    logic [11:0] m_p2   [3];
    logic [11:0] m_s    [3];
    logic [11:0] m_hist [3][8];
    int          m_n    [3];

    function automatic int depth_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic model_one(input int i, input logic r, input logic [3:0] p,
                             input logic [7:0] s, output logic [20:0] w);
        logic [11:0] seen;
        logic [11:0] old_s;
        logic [11:0] new_s;
        bit          all_opp;
        int          d;
        d = depth_of(i);
        if (r) begin
            m_p1[i] = '0;
            m_p2[i] = '0;
            m_s[i]  = '0;
            m_n[i]  = 0;
            w = '0;
        end else begin
            // What the debounce logic sees this edge is the pin value from two
            // edges ago, with the optional button inversion.
            seen = m_p2[i] ^ ((i == 1) ? 12'h00F : 12'h000);
            m_p2[i] = m_p1[i];
            m_p1[i] = {s, p};
            for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = seen;
            if (m_n[i] < 8) m_n[i]++;
            old_s = m_s[i];
            new_s = old_s;
            for (int b = 0; b < 12; b++) begin
                if (m_n[i] >= d) begin
                    all_opp = 1'b1;
                    for (int k = 0; k < d; k++)
                        if (m_hist[i][k][b] == old_s[b]) all_opp = 1'b0;
                    if (all_opp) new_s[b] = ~old_s[b];
                end
            end
            m_s[i] = new_s;
            w = {new_s[3:0], new_s[3:0] & ~old_s[3:0], ~new_s[3:0] & old_s[3:0],
                 new_s[11:4], |(new_s[11:4] ^ old_s[11:4])};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: predict at the edge, compare #1 later.
    task automatic step();
        logic [20:0] w0, w1, w2;
        logic [62:0] e;
        logic [20:0] act [3];
        @(posedge clk);
        model_one(0, rst, pb,   sw, w0);
        model_one(1, rst, pb_b, sw, w1);
        model_one(2, rst, pb,   sw, w2);
        exp_q.push_back({w2, w1, w0});
        #1;
        cyc++;
        act[0] = {pb_level_a, pb_press_a, pb_release_a, sw_level_a, sw_change_a};
        act[1] = {pb_level_b, pb_press_b, pb_release_b, sw_level_b, sw_change_b};
        act[2] = {pb_level_c, pb_press_c, pb_release_c, sw_level_c, sw_change_c};
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (act[i] !== e[i*21 +: 21]) begin
                bad++;
                $display("FAIL model_inst%0d cyc=%0d got=%h expected=%h", i, cyc, act[i], e[i*21 +: 21]);
            end
        end
        if (pb_press_a[1]) press1_cnt++;
        if (sw_change_a)   chg_cnt++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] pb;
        logic [3:0] pb_b;
        logic [7:0] sw;
        int         cycles;
        logic [3:0] exp_pb_a;
        logic [3:0] exp_pb_b;
        logic [7:0] exp_sw;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            m_p1[i] = '0; m_p2[i] = '0; m_s[i] = '0; m_n[i] = 0;
            for (int k = 0; k < 8; k++) m_hist[i][k] = '0;
        end

        // Latency with D=4 is 5 edges of no change, the level flips on the 6th.
        tbl[0]  = '{1'b1, 4'hF, 4'hF, 8'hFF,  3, 4'h0, 4'h0, 8'h00}; // reset with pins active
        tbl[1]  = '{1'b0, 4'hF, 4'hF, 8'hFF,  5, 4'h0, 4'h0, 8'h00}; // not yet
        tbl[2]  = '{1'b0, 4'hF, 4'hF, 8'hFF,  1, 4'hF, 4'h0, 8'hFF}; // post-reset press
        tbl[3]  = '{1'b0, 4'h0, 4'hF, 8'h00, 20, 4'h0, 4'h0, 8'h00}; // all released
        tbl[4]  = '{1'b0, 4'h1, 4'hF, 8'h00,  5, 4'h0, 4'h0, 8'h00}; // pb0 rising, pending
        tbl[5]  = '{1'b0, 4'h1, 4'hF, 8'h00,  1, 4'h1, 4'h0, 8'h00}; // pb0 pressed
        tbl[6]  = '{1'b0, 4'h1, 4'hF, 8'h00, 20, 4'h1, 4'h0, 8'h00}; // held
        tbl[7]  = '{1'b0, 4'h0, 4'hF, 8'h00,  5, 4'h1, 4'h0, 8'h00}; // falling, pending
        tbl[8]  = '{1'b0, 4'h0, 4'hF, 8'h00,  1, 4'h0, 4'h0, 8'h00}; // released
        tbl[9]  = '{1'b0, 4'hC, 4'hF, 8'hA5,  6, 4'hC, 4'h0, 8'hA5}; // simultaneous
        tbl[10] = '{1'b0, 4'hC, 4'hF, 8'hA5,  3, 4'hC, 4'h0, 8'hA5}; // hold
        tbl[11] = '{1'b0, 4'hC, 4'hB, 8'hA5,  6, 4'hC, 4'h4, 8'hA5}; // active-low pb2 press
        tbl[12] = '{1'b0, 4'hC, 4'hF, 8'hA5,  6, 4'hC, 4'h0, 8'hA5}; // active-low release

        for (int r = 0; r < 13; r++) begin
            rst = tbl[r].rst; pb = tbl[r].pb; pb_b = tbl[r].pb_b; sw = tbl[r].sw;
            steps(tbl[r].cycles);
            chk($sformatf("tbl%0d_pb_a", r), 32'(pb_level_a), 32'(tbl[r].exp_pb_a));
            chk($sformatf("tbl%0d_pb_b", r), 32'(pb_level_b), 32'(tbl[r].exp_pb_b));
            chk($sformatf("tbl%0d_sw_a", r), 32'(sw_level_a), 32'(tbl[r].exp_sw));
        end

        // ---------------- bounce rejection ----------------
        pb = 4'h0; sw = 8'h00; pb_b = 4'hF;
        steps(8);
        press1_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            pb[1] = 1'b1; steps(3);
            pb[1] = 1'b0; steps(2);
        end
        steps(10);
        chk("bounce0_press_cnt", 32'(press1_cnt), 32'd0);
        chk("bounce0_level", 32'(pb_level_a[1]), 32'd0);

        press1_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            pb[1] = 1'b1; steps(3);
            pb[1] = 1'b0; steps(2);
        end
        pb[1] = 1'b1;
        steps(10);
        chk("bounce1_press_cnt", 32'(press1_cnt), 32'd1);
        chk("bounce1_level", 32'(pb_level_a[1]), 32'd1);
        pb = 4'h0;
        steps(8);

        // ---------------- consecutive switch changes ----------------
        chg_cnt = 0;
        sw = 8'h01; step();
        sw = 8'h03; steps(10);
        chk("sw_consec_cnt", 32'(chg_cnt), 32'd2);
        chk("sw_consec_level", 32'(sw_level_a), 32'h03);

        // ---------------- reset mid-count ----------------
        sw = 8'h00; steps(8);
        sw = 8'h80; steps(2);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("midreset_level", 32'(sw_level_a), 32'h00);
        n = 0;
        while (!sw_level_a[7] && n < 20) begin
            step();
            n++;
        end
        chk("midreset_latency", 32'(n), 32'd6);

        // ---------------- randomized ----------------
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) pb   = 4'($urandom);
            if ($urandom_range(0, 5) == 0) pb_b = 4'($urandom);
            if ($urandom_range(0, 6) == 0) sw   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pb[$urandom_range(0, 3)] = ~pb[0];
            step();
        end
        rst = 1'b0;
        steps(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
